// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register unit with single-cycle multiply and a
// multi-cycle radix-2 restoring divider.
//
// Operations (op_code):
//   000 MTHI  : hi_o <= src_a
//   001 MTLO  : lo_o <= src_a
//   010 MULT  : {hi_o,lo_o} <= signed   src_a * src_b
//   011 MULTU : {hi_o,lo_o} <= unsigned src_a * src_b
//   100 DIV   : lo_o <= quotient, hi_o <= remainder (signed, WIDTH cycles)
//   101 DIVU  : lo_o <= quotient, hi_o <= remainder (unsigned, WIDTH cycles)
//   110/111   : no-op
//
// Ports:
//   clk      - clock, all state changes on its rising edge
//   rst      - synchronous active-high reset
//   op_valid - operation request
//   op_code  - operation select (see above)
//   src_a    - operand A / dividend
//   src_b    - operand B / divisor
//   cancel   - flush: aborts an in-flight divide, drops a concurrent request
//   op_ready - a new request can be accepted (~busy)
//   busy     - divide in progress
//   done     - one-cycle pulse following every HI/LO update
//   hi_o     - committed HI register
//   lo_o     - committed LO register

module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DIV  = 1'b1;

    localparam logic [2:0] OP_MTHI  = 3'b000;
    localparam logic [2:0] OP_MTLO  = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_MULTU = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic             neg_q;
    logic             neg_r;

    assign busy     = (state == S_DIV);
    assign op_ready = ~busy;

    // Multiply: sign- or zero-extend to 2*WIDTH, then keep the low 2*WIDTH
    // bits of the product, which is exact in either interpretation.
    logic [2*WIDTH-1:0] a_ext, b_ext, product;
    logic               mul_signed;

    // Divide operand preparation: magnitudes plus result signs.
    logic             div_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One restoring iteration on the current divider state.
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt, quo_nxt, q_fix, r_fix;

    // NOTE: every signal is given a value on every path through this block,
    // so no latch can be inferred.
    always_comb begin
        mul_signed = (op_code == OP_MULT);
        a_ext      = {{WIDTH{mul_signed & src_a[WIDTH-1]}}, src_a};
        b_ext      = {{WIDTH{mul_signed & src_b[WIDTH-1]}}, src_b};
        product    = a_ext * b_ext;

        div_signed = (op_code == OP_DIV);
        a_neg      = div_signed & src_a[WIDTH-1];
        b_neg      = div_signed & src_b[WIDTH-1];
        // The most negative value maps onto its correct unsigned magnitude.
        a_mag      = a_neg ? -src_a : src_a;
        b_mag      = b_neg ? -src_b : src_b;

        trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        if (trial[WIDTH]) begin
            rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end

        q_fix = neg_q ? -quo_nxt : quo_nxt;
        r_fix = neg_r ? -rem_nxt : rem_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the divider datapath registers are reset along with the
            // architectural state so nothing stale survives a reset.
            state <= S_IDLE;
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_o  <= '0;
            lo_o  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid && !cancel) begin
                        case (op_code)
                            OP_MTHI: begin
                                hi_o <= src_a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_o <= src_a;
                                done <= 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
                                {hi_o, lo_o} <= product;
                                done         <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (src_b == '0) begin
                                    // Divide-by-zero resolves immediately.
                                    lo_o <= '1;
                                    hi_o <= src_a;
                                    done <= 1'b1;
                                end else begin
                                    rem   <= '0;
                                    quo   <= a_mag;
                                    dvs   <= b_mag;
                                    neg_q <= a_neg ^ b_neg;
                                    neg_r <= a_neg;
                                    count <= '0;
                                    state <= S_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        // Flush wins even on the final iteration.
                        state <= S_IDLE;
                    end else begin
                        rem   <= rem_nxt;
                        quo   <= quo_nxt;
                        count <= count + 1'b1;
                        if (count == LAST_ITER) begin
                            lo_o  <= q_fix;
                            hi_o  <= r_fix;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

    localparam int W = 32;

    localparam logic [2:0] MTHI  = 3'b000;
    localparam logic [2:0] MTLO  = 3'b001;
    localparam logic [2:0] MULT  = 3'b010;
    localparam logic [2:0] MULTU = 3'b011;
    localparam logic [2:0] DIV   = 3'b100;
    localparam logic [2:0] DIVU  = 3'b101;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op_code;
    logic [W-1:0] src_a, src_b;
    logic         cancel;
    logic         op_ready, busy, done;
    logic [W-1:0] hi_o, lo_o;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural HI/LO plus the number of edges left
    // before a pending divide result lands.
    logic [W-1:0] m_hi, m_lo, m_q, m_r;
    logic         m_done;
    int           m_left;

    always @(posedge clk) begin
        longint       sa, sb, tq, tr;
        logic [63:0]  p;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left != 0) begin
                if (cancel) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = m_r; m_lo = m_q; m_done = 1'b1;
                    end
                end
            end else if (op_valid && !cancel) begin
                case (op_code)
                    MTHI: begin m_hi = src_a; m_done = 1'b1; end
                    MTLO: begin m_lo = src_a; m_done = 1'b1; end
                    MULT: begin
                        p = 64'(longint'($signed(src_a)) * longint'($signed(src_b)));
                        {m_hi, m_lo} = p; m_done = 1'b1;
                    end
                    MULTU: begin
                        p = 64'(src_a) * 64'(src_b);
                        {m_hi, m_lo} = p; m_done = 1'b1;
                    end
                    DIV, DIVU: begin
                        if (src_b == '0) begin
                            m_lo = '1; m_hi = src_a; m_done = 1'b1;
                        end else begin
                            if (op_code == DIV) begin
                                sa = longint'($signed(src_a));
                                sb = longint'($signed(src_b));
                            end else begin
                                sa = longint'(src_a);
                                sb = longint'(src_b);
                            end
                            tq = sa / sb;
                            tr = sa % sb;
                            m_q = tq[W-1:0];
                            m_r = tr[W-1:0];
                            m_left = W;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     busy,     m_left != 0);
            check("op_ready", op_ready, m_left == 0);
            check("done",     done,     m_done);
            check("hi_o",     hi_o,     m_hi);
            check("lo_o",     lo_o,     m_lo);
        end
    end

    // Apply inputs for one edge; returns at the following negedge.
    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        op_valid = v; op_code = op; src_a = a; src_b = b; cancel = c;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 3'b111, '0, '0, 1'b0);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return W'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    int busy_cycles;

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = '0; src_a = '0; src_b = '0; cancel = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", op_ready, 1);

        // MTHI then MTLO back to back
        drive(1'b1, MTHI, 32'hDEAD_BEEF, '0, 1'b0);
        check("mthi_done", done, 1);
        check("mthi_hi", hi_o, 32'hDEAD_BEEF);
        drive(1'b1, MTLO, 32'h1234_5678, '0, 1'b0);
        check("mtlo_done", done, 1);
        check("mtlo_hi", hi_o, 32'hDEAD_BEEF);
        check("mtlo_lo", lo_o, 32'h1234_5678);
        idle();
        check("idle_done", done, 0);

        // MULT / MULTU
        drive(1'b1, MULT, 32'hFFFF_FFFE, 32'h3, 1'b0);
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFFA);
        drive(1'b1, MULTU, 32'hFFFF_FFFE, 32'h3, 1'b0);
        check("multu_hi", hi_o, 32'h0000_0002);
        check("multu_lo", lo_o, 32'hFFFF_FFFA);

        // DIV -7 / 2 with an MTHI attempted mid-divide
        drive(1'b1, DIV, 32'hFFFF_FFF9, 32'h2, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            if (i == 5) begin
                drive(1'b1, MTHI, 32'h1111_1111, '0, 1'b0);
                check("div_mthi_ignored", hi_o, 32'h0000_0002);
            end else idle();
        end
        check("div_busy_cycles", busy_cycles, 32);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);
        check("div_done", done, 1);
        idle();
        check("div_done_pulse", done, 0);

        // DIVU by zero
        drive(1'b1, DIVU, 32'd100, '0, 1'b0);
        check("dz_busy", busy, 0);
        check("dz_lo", lo_o, 32'hFFFF_FFFF);
        check("dz_hi", hi_o, 32'h0000_0064);
        check("dz_done", done, 1);

        // Signed overflow min / -1
        drive(1'b1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 40 && busy; i++) idle();
        check("ovf_busy", busy, 0);
        check("ovf_lo", lo_o, 32'h8000_0000);
        check("ovf_hi", hi_o, 32'h0000_0000);

        // Cancel at E10
        drive(1'b1, DIV, 32'd1000, 32'd7, 1'b0);
        repeat (9) idle();
        drive(1'b0, 3'b111, '0, '0, 1'b1);
        check("cancel_busy", busy, 0);
        check("cancel_ready", op_ready, 1);
        check("cancel_done", done, 0);
        check("cancel_hi", hi_o, 32'h0000_0000);
        check("cancel_lo", lo_o, 32'h8000_0000);
        idle();
        check("cancel_no_done", done, 0);

        // Reset at E5 of a new divide
        drive(1'b1, DIV, 32'd12345, 32'd67, 1'b0);
        repeat (4) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("rstdiv_hi", hi_o, 0);
        check("rstdiv_lo", lo_o, 0);
        check("rstdiv_busy", busy, 0);
        check("rstdiv_done", done, 0);
        check("rstdiv_ready", op_ready, 1);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                  $urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        repeat (40) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
